// File: rtl/sccb_cfg_sequencer.sv
// Table-driven SCCB configuration sequencer: power-up wait, product-ID check,
// then walks a {sub_addr, value} ROM issuing SCCB writes until an end marker.
module sccb_cfg_sequencer #(
  parameter int unsigned TICKS_PER_MS   = 10000,
  parameter int unsigned PWR_DELAY_MS   = 10,
  parameter logic [6:0]  DEV_ID         = 7'h21,
  parameter logic [7:0]  PID_REG        = 8'h0A,
  parameter logic [7:0]  PID_EXPECT     = 8'h76,
  parameter int unsigned ROM_AW         = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic              PCLK,
  input  logic              PRESETN,
  input  logic              go,
  input  logic              auto_start,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sccb_start,
  output logic              sccb_rw,
  output logic [6:0]        sccb_id_addr,
  output logic [7:0]        sccb_sub_addr,
  output logic [7:0]        sccb_wdata,
  input  logic [7:0]        sccb_rdata,
  input  logic              sccb_done,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err,
  output logic [1:0]        err_code,
  output logic [ROM_AW-1:0] wr_count
);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StPwrWait = 4'd1;
  localparam logic [3:0] StIdRd    = 4'd2;
  localparam logic [3:0] StIdChk   = 4'd3;
  localparam logic [3:0] StFetch   = 4'd4;
  localparam logic [3:0] StDecode  = 4'd5;
  localparam logic [3:0] StWr      = 4'd6;
  localparam logic [3:0] StGap     = 4'd7;
  localparam logic [3:0] StDly     = 4'd8;
  localparam logic [3:0] StDone    = 4'd9;
  localparam logic [3:0] StErr     = 4'd10;

  localparam logic [31:0] PwrTicks  = 32'(PWR_DELAY_MS * TICKS_PER_MS);
  localparam logic [31:0] ToLast    = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  ErrId     = 2'b01;
  localparam logic [1:0]  ErrTo     = 2'b10;
  localparam logic [1:0]  ErrOvr    = 2'b11;

  logic [3:0]        state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       dly_tgt_q, dly_tgt_d;
  logic [31:0]       to_cnt_q, to_cnt_d;
  logic              done_q;
  logic              first_q;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              start_q, start_d;
  logic              rw_q, rw_d;
  logic [7:0]        sub_q, sub_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        pid_q, pid_d;
  logic              cfg_done_q, cfg_done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [ROM_AW-1:0] wr_count_q, wr_count_d;

  logic done_rise;
  logic timeout;
  logic addr_last;

  assign done_rise = sccb_done & ~done_q;
  assign addr_last = (rom_addr_q == {ROM_AW{1'b1}});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dly_tgt_d  = dly_tgt_q;
    to_cnt_d   = to_cnt_q;
    rom_addr_d = rom_addr_q;
    start_d    = start_q;
    rw_d       = rw_q;
    sub_d      = sub_q;
    wdata_d    = wdata_q;
    pid_d      = pid_q;
    cfg_done_d = cfg_done_q;
    cfg_err_d  = cfg_err_q;
    err_code_d = err_code_q;
    wr_count_d = wr_count_q;
    timeout    = 1'b0;

    if (start_q) begin
      if (to_cnt_q == ToLast) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end

    case (state_q)
      StIdle: begin
        // go and the post-reset auto start collapse into one start
        if (go || (first_q && auto_start)) begin
          cfg_done_d = 1'b0;
          cfg_err_d  = 1'b0;
          err_code_d = 2'b00;
          wr_count_d = '0;
          rom_addr_d = '0;
          cnt_d      = '0;
          state_d    = StPwrWait;
        end
      end
      StPwrWait: begin
        if (cnt_q + 32'd1 >= PwrTicks) begin
          start_d  = 1'b1;
          rw_d     = 1'b1;
          sub_d    = PID_REG;
          to_cnt_d = '0;
          state_d  = StIdRd;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StIdRd: begin
        if (timeout) begin
          start_d    = 1'b0;
          err_code_d = ErrTo;
          state_d    = StErr;
        end else if (done_rise) begin
          pid_d   = sccb_rdata;
          start_d = 1'b0;
          state_d = StIdChk;
        end
      end
      StIdChk: begin
        if (pid_q != PID_EXPECT) begin
          err_code_d = ErrId;
          state_d    = StErr;
        end else begin
          rom_addr_d = '0;
          state_d    = StFetch;
        end
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (rom_data == 16'hFFFF) begin
          state_d = StDone;
        end else if (rom_data[15:8] == 8'hFE) begin
          dly_tgt_d = (rom_data[7:0] == 8'd0) ? 32'd1 :
                      32'(rom_data[7:0]) * TICKS_PER_MS;
          cnt_d     = '0;
          state_d   = StDly;
        end else begin
          sub_d    = rom_data[15:8];
          wdata_d  = rom_data[7:0];
          rw_d     = 1'b0;
          start_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = StWr;
        end
      end
      StWr: begin
        if (timeout) begin
          start_d    = 1'b0;
          err_code_d = ErrTo;
          state_d    = StErr;
        end else if (done_rise) begin
          start_d    = 1'b0;
          wr_count_d = wr_count_q + ROM_AW'(1);
          if (addr_last) begin
            err_code_d = ErrOvr;
            state_d    = StErr;
          end else begin
            rom_addr_d = rom_addr_q + ROM_AW'(1);
            state_d    = StGap;
          end
        end
      end
      StGap: begin
        // never re-request while the previous done level is still high
        if (!sccb_done) state_d = StFetch;
      end
      StDly: begin
        if (cnt_q + 32'd1 >= dly_tgt_q) begin
          if (addr_last) begin
            err_code_d = ErrOvr;
            state_d    = StErr;
          end else begin
            rom_addr_d = rom_addr_q + ROM_AW'(1);
            state_d    = StFetch;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StDone: begin
        cfg_done_d = 1'b1;
        state_d    = StIdle;
      end
      StErr: begin
        cfg_err_d = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dly_tgt_q  <= '0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      first_q    <= 1'b1;
      rom_addr_q <= '0;
      start_q    <= 1'b0;
      rw_q       <= 1'b0;
      sub_q      <= '0;
      wdata_q    <= '0;
      pid_q      <= '0;
      cfg_done_q <= 1'b0;
      cfg_err_q  <= 1'b0;
      err_code_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dly_tgt_q  <= dly_tgt_d;
      to_cnt_q   <= to_cnt_d;
      done_q     <= sccb_done;
      first_q    <= 1'b0;
      rom_addr_q <= rom_addr_d;
      start_q    <= start_d;
      rw_q       <= rw_d;
      sub_q      <= sub_d;
      wdata_q    <= wdata_d;
      pid_q      <= pid_d;
      cfg_done_q <= cfg_done_d;
      cfg_err_q  <= cfg_err_d;
      err_code_q <= err_code_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rom_addr      = rom_addr_q;
  assign sccb_start    = start_q;
  assign sccb_rw       = rw_q;
  assign sccb_id_addr  = DEV_ID;
  assign sccb_sub_addr = sub_q;
  assign sccb_wdata    = wdata_q;
  assign busy          = (state_q != StIdle);
  assign cfg_done      = cfg_done_q;
  assign cfg_err       = cfg_err_q;
  assign err_code      = err_code_q;
  assign wr_count      = wr_count_q;

endmodule

// File: tb/tb_sccb_cfg_sequencer.sv
// Bench for sccb_cfg_sequencer: SCCB slave and ROM models, a transaction
// scoreboard fed from a table-walking reference model, and outcome checks.
module tb_sccb_cfg_sequencer;

  localparam int unsigned Ticks   = 10;
  localparam int unsigned PwrMs   = 1;
  localparam int unsigned Aw      = 2;
  localparam int unsigned Timeout = 50;
  localparam int unsigned Entries = 1 << Aw;

  logic          PCLK = 1'b0;
  logic          PRESETN;
  logic          go;
  logic          auto_start;
  logic [Aw-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          sccb_start;
  logic          sccb_rw;
  logic [6:0]    sccb_id_addr;
  logic [7:0]    sccb_sub_addr;
  logic [7:0]    sccb_wdata;
  logic [7:0]    sccb_rdata;
  logic          sccb_done;
  logic          busy;
  logic          cfg_done;
  logic          cfg_err;
  logic [1:0]    err_code;
  logic [Aw-1:0] wr_count;

  sccb_cfg_sequencer #(
    .TICKS_PER_MS  (Ticks),
    .PWR_DELAY_MS  (PwrMs),
    .ROM_AW        (Aw),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .PCLK         (PCLK),
    .PRESETN      (PRESETN),
    .go           (go),
    .auto_start   (auto_start),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .sccb_start   (sccb_start),
    .sccb_rw      (sccb_rw),
    .sccb_id_addr (sccb_id_addr),
    .sccb_sub_addr(sccb_sub_addr),
    .sccb_wdata   (sccb_wdata),
    .sccb_rdata   (sccb_rdata),
    .sccb_done    (sccb_done),
    .busy         (busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err),
    .err_code     (err_code),
    .wr_count     (wr_count)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    bit         rw;
    logic [7:0] sub;
    logic [7:0] wd;
    int         min_gap;
    bit         to;
  } txn_t;

  txn_t        exp_q[$];
  logic [15:0] rom_mem [Entries];
  logic [7:0]  pid_val;
  bit          no_resp;
  int          checks;
  int          failures;
  int          cyc;
  int          ref_cyc;
  bit          exp_done;
  bit          exp_err;
  logic [1:0]  exp_code;
  int          exp_wr;

  always @(posedge PCLK) cyc <= cyc + 1;
  always @(posedge PCLK) rom_data <= rom_mem[rom_addr];

  // SCCB slave: random latency to done, done held 1..3 cycles
  int sl_ph;
  int sl_cnt;
  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      sl_ph      <= 0;
      sl_cnt     <= 0;
      sccb_done  <= 1'b0;
      sccb_rdata <= 8'h00;
    end else begin
      case (sl_ph)
        0: if (sccb_start && !sccb_done) begin
          sl_cnt <= int'($urandom_range(4, 0));
          sl_ph  <= 1;
        end
        1: if (!sccb_start) begin
          sl_ph <= 0;
        end else if (sl_cnt == 0) begin
          if (!no_resp) begin
            sccb_done  <= 1'b1;
            sccb_rdata <= sccb_rw ? pid_val : 8'($urandom);
            sl_cnt     <= int'($urandom_range(2, 0));
            sl_ph      <= 2;
          end
        end else begin
          sl_cnt <= sl_cnt - 1;
        end
        2: if (sl_cnt == 0) begin
          sccb_done <= 1'b0;
          sl_ph     <= 3;
        end else begin
          sl_cnt <= sl_cnt - 1;
        end
        default: if (!sccb_start) sl_ph <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int lo);
    checks++;
    if (act < lo) begin
      failures++;
      $display("FAIL %s: got %0d required >= %0d (t=%0t)", name, act, lo, $time);
    end
  endtask

  // Reference model: walk the table by its rules and list the expected bus traffic.
  task automatic build_expect();
    int gap;
    int writes;
    bit ended;
    logic [15:0] e;
    exp_q.delete();
    exp_q.push_back('{rw: 1'b1, sub: 8'h0A, wd: 8'h00, min_gap: int'(PwrMs * Ticks), to: no_resp});
    exp_done = 1'b0;
    exp_err  = 1'b1;
    exp_wr   = 0;
    if (no_resp) begin
      exp_code = 2'b10;
    end else if (pid_val != 8'h76) begin
      exp_code = 2'b01;
    end else begin
      gap    = 1;
      writes = 0;
      ended  = 1'b0;
      for (int a = 0; a < int'(Entries); a++) begin
        e = rom_mem[a];
        if (e == 16'hFFFF) begin
          ended = 1'b1;
          break;
        end else if (e[15:8] == 8'hFE) begin
          gap += (e[7:0] == 8'd0) ? 1 : int'(e[7:0]) * int'(Ticks);
        end else begin
          exp_q.push_back('{rw: 1'b0, sub: e[15:8], wd: e[7:0], min_gap: gap, to: 1'b0});
          gap = 1;
          writes++;
        end
      end
      exp_wr   = writes % int'(Entries);
      exp_done = ended;
      exp_err  = !ended;
      exp_code = ended ? 2'b00 : 2'b11;
    end
  endtask

  // Monitor: pops one expected transaction per sccb_start rise
  initial begin
    bit ps, pd, stable;
    int hi;
    txn_t cur;
    logic [7:0] cs, cw;
    ps = 1'b0; pd = 1'b0; stable = 1'b1; hi = 0; cs = '0; cw = '0;
    cur = '{rw: 1'b0, sub: 8'h00, wd: 8'h00, min_gap: 0, to: 1'b0};
    forever begin
      @(negedge PCLK);
      if (!PRESETN) begin
        ps = 1'b0;
        pd = 1'b0;
      end else begin
        if (sccb_done && !pd) ref_cyc = cyc;
        if (sccb_start && !ps) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_txn: got rw=%0b sub=0x%0h, expected no transaction",
                     sccb_rw, sccb_sub_addr);
            cur = '{rw: 1'b0, sub: 8'h00, wd: 8'h00, min_gap: 0, to: 1'b0};
          end else begin
            cur = exp_q.pop_front();
            chk("txn_rw", sccb_rw, cur.rw);
            chk("txn_sub", sccb_sub_addr, cur.sub);
            chk("txn_id", sccb_id_addr, 7'h21);
            if (!cur.rw) chk("txn_wdata", sccb_wdata, cur.wd);
            chk_ge("txn_gap", cyc - ref_cyc, cur.min_gap);
          end
          cs = sccb_sub_addr;
          cw = sccb_wdata;
          hi = 0;
          stable = 1'b1;
        end
        if (sccb_start) begin
          hi++;
          if (sccb_sub_addr != cs || sccb_wdata != cw) stable = 1'b0;
        end
        if (!sccb_start && ps) begin
          chk("txn_stable", stable, 1);
          if (cur.to) chk("timeout_len", hi, Timeout);
        end
        ps = sccb_start;
        pd = sccb_done;
      end
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_start"}, sccb_start, 0);
    chk({tag, "_rw"}, sccb_rw, 0);
    chk({tag, "_sub"}, sccb_sub_addr, 0);
    chk({tag, "_wdata"}, sccb_wdata, 0);
    chk({tag, "_id"}, sccb_id_addr, 7'h21);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_done"}, cfg_done, 0);
    chk({tag, "_cfg_err"}, cfg_err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_wr_count"}, wr_count, 0);
  endtask

  task automatic start_go();
    build_expect();
    @(negedge PCLK);
    go = 1'b1;
    @(posedge PCLK);
    #1;
    ref_cyc = cyc;
    go = 1'b0;
    chk("busy_after_go", busy, 1);
    // a go while busy must be ignored
    repeat (2) @(negedge PCLK);
    go = 1'b1;
    @(negedge PCLK);
    go = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_wait: busy still %0b after %0d cycles", tag, busy, n);
    end
  endtask

  task automatic check_outcome(input string tag);
    wait_idle(tag);
    @(negedge PCLK);
    chk({tag, "_cfg_done"}, cfg_done, exp_done);
    chk({tag, "_cfg_err"}, cfg_err, exp_err);
    chk({tag, "_err_code"}, err_code, exp_code);
    chk({tag, "_wr_count"}, wr_count, exp_wr);
    chk({tag, "_pending_txns"}, exp_q.size(), 0);
  endtask

  task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    rom_mem[0] = e0;
    rom_mem[1] = e1;
    rom_mem[2] = e2;
    rom_mem[3] = e3;
  endtask

  initial begin
    int n;
    PRESETN = 1'b0; go = 1'b0; auto_start = 1'b1; no_resp = 1'b0; pid_val = 8'h76;
    checks = 0; failures = 0;
    load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    build_expect();
    repeat (2) @(negedge PCLK);
    chk_reset("rst");
    PRESETN = 1'b1;
    @(posedge PCLK);
    #1;
    ref_cyc = cyc;
    chk("auto_busy", busy, 1);
    auto_start = 1'b0;
    check_outcome("auto");

    pid_val = 8'h77;
    start_go();
    check_outcome("id_bad");
    chk("id_bad_rom_addr", rom_addr, 0);

    pid_val = 8'h76;
    load_rom(16'h1280, 16'hFE03, 16'h1101, 16'hFFFF);
    start_go();
    check_outcome("delay");

    no_resp = 1'b1;
    start_go();
    check_outcome("timeout");
    no_resp = 1'b0;

    load_rom(16'h1280, 16'h1301, 16'h1402, 16'h1503);
    start_go();
    check_outcome("overrun");

    load_rom(16'h1280, 16'h1101, 16'hFFFF, 16'h0000);
    start_go();
    n = 0;
    while (!(sccb_start && !sccb_rw) && n < 500) begin
      @(negedge PCLK);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL mid_wr_wait: no write seen after %0d cycles", n);
    end
    #2;
    PRESETN = 1'b0;
    #1;
    chk_reset("mid_rst");
    exp_q.delete();
    repeat (3) @(negedge PCLK);
    PRESETN = 1'b1;
    repeat (5) @(negedge PCLK);
    chk("no_auto_busy", busy, 0);
    start_go();
    check_outcome("restart");

    for (int t = 0; t < 6; t++) begin
      for (int a = 0; a < int'(Entries); a++) begin
        int k;
        k = int'($urandom_range(9, 0));
        if (k < 2) rom_mem[a] = 16'hFFFF;
        else if (k < 4) rom_mem[a] = {8'hFE, 8'($urandom_range(3, 0))};
        else rom_mem[a] = 16'($urandom);
      end
      pid_val = ($urandom_range(3, 0) == 0) ? (8'h76 ^ 8'($urandom_range(255, 1))) : 8'h76;
      start_go();
      check_outcome("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/sccb_cfg_sequencer.md
Name: sccb_cfg_sequencer

Overview:
- Table-driven configuration controller for the camera SCCB master.
- After reset or a `go` request it does four things in order: waits for sensor power-up, reads and checks the product ID, walks a register/value ROM issuing SCCB writes, and reports done or error.
- Sits between the system clock domain (PCLK) and the SCCB master core. It replaces the hand-written write/read sequences with a scalable init table.

Parameters:
- TICKS_PER_MS, 10000, PCLK cycles per millisecond (10 MHz default).
- PWR_DELAY_MS, 10, delay after start before the first SCCB transaction.
- DEV_ID, 7'h21, 7-bit SCCB device address.
- PID_REG, 8'h0A, product ID register address.
- PID_EXPECT, 8'h76, required product ID value.
- ROM_AW, 8, table address width; up to 2^ROM_AW entries.
- TIMEOUT_CYCLES, 200000, maximum PCLK cycles from sccb_start to sccb_done.

Ports:
- PCLK  in  1  system clock.
- PRESETN  in  1  asynchronous active-low reset.
- go  in  1  one-cycle pulse; restarts the sequence from power wait. Ignored while busy.
- auto_start  in  1  when 1, the sequence starts automatically on reset release.
- rom_addr  out  ROM_AW  table address.
- rom_data  in  16  table entry {sub_addr[15:8], value[7:0]}; synchronous ROM, valid 1 cycle after rom_addr.
- sccb_start  out  1  transaction request to the SCCB master; level signal.
- sccb_rw  out  1  0 = write, 1 = read.
- sccb_id_addr  out  7  device address.
- sccb_sub_addr  out  8  register address.
- sccb_wdata  out  8  write data.
- sccb_rdata  in  8  read data; valid when sccb_done is asserted.
- sccb_done  in  1  transaction complete; may be a multi-cycle level, and is edge-detected inside the block.
- busy  out  1  sequence in progress.
- cfg_done  out  1  sticky; the table completed successfully.
- cfg_err  out  1  sticky; the sequence aborted.
- err_code  out  2  error cause: 01 = ID mismatch, 10 = SCCB timeout, 11 = table overrun.
- wr_count  out  ROM_AW  number of table writes completed.

Behaviour:
- Reset values: all outputs 0, except sccb_id_addr = DEV_ID.
- After reset, if auto_start = 1 the FSM enters PWR_WAIT on the first clock; otherwise it stays in IDLE.
- IDLE:
  - busy = 0.
  - A `go` pulse clears cfg_done, cfg_err, err_code and wr_count, then moves to PWR_WAIT.
- PWR_WAIT:
  - Counts PWR_DELAY_MS*TICKS_PER_MS cycles, then goes to ID_RD.
  - PWR_DELAY_MS = 0 skips the wait after one cycle.
- ID_RD:
  - Drives sccb_rw = 1, sccb_sub_addr = PID_REG, sccb_start = 1.
  - On the rising edge of sccb_done, captures sccb_rdata, drops sccb_start, and goes to ID_CHK.
- ID_CHK:
  - Mismatch → ERR with code 01.
  - Match → rom_addr = 0, then FETCH.
- FETCH: one-cycle ROM latency wait, then DECODE.
- DECODE:
  - Entry 16'hFFFF is the end marker → DONE.
  - Entry {8'hFE, N} is a delay entry → DLY for N ms; N = 0 means one cycle.
  - Any other entry → WR, with sccb_sub_addr = rom_data[15:8] and sccb_wdata = rom_data[7:0].
- WR:
  - sccb_rw = 0, sccb_start = 1, held until the rising edge of sccb_done.
  - On that edge: sccb_start = 0, wr_count is incremented, rom_addr is incremented, then GAP.
- GAP:
  - Holds sccb_start low for one cycle, and until sccb_done has returned low, then goes to FETCH.
  - A new transaction is never requested while sccb_done is still high.
- DLY:
  - After the count: rom_addr is incremented, then FETCH.
  - The increment rule from WR and DLY applies here.
- Table overrun:
  - rom_addr would wrap from 2^ROM_AW-1 to 0 without an end marker having been seen → ERR with code 11.
  - This check takes priority over the address increment.
- Timeout:
  - A cycle counter is cleared on every assertion of sccb_start.
  - If it reaches TIMEOUT_CYCLES while sccb_start is high → sccb_start = 0, ERR with code 10.
- DONE: cfg_done = 1, busy = 0, then IDLE.
- ERR: cfg_err = 1, busy = 0, err_code is latched, then IDLE.
- busy = 1 in every state except IDLE.
- `go` pulses that arrive while busy are dropped.
- sccb_id_addr is constant DEV_ID.
- sccb_sub_addr and sccb_wdata are stable for the whole time sccb_start is high.
- Reset mid-transaction: all outputs return to reset values immediately. sccb_start drops asynchronously.
- If a `go` pulse and auto-start occur in the same cycle, they are treated as a single start.

Test Plan:
- auto_start = 1, PWR_DELAY_MS = 1, TICKS_PER_MS = 10, model returns 0x76, ROM = {1280, 1101, FFFF} → ID read, then writes (12,80) and (11,01) in order; cfg_done = 1, wr_count = 2, no write before 10 cycles.
- Model returns 0x77 → cfg_err = 1, err_code = 01, no writes issued, rom_addr stays 0.
- ROM = {1280, FE03, 1101, FFFF}, TICKS_PER_MS = 10 → gap between the first done and the second start is ≥ 30 cycles; wr_count = 2.
- Model never asserts done, TIMEOUT_CYCLES = 50 → sccb_start drops at cycle 50; err_code = 10.
- ROM_AW = 2, no end marker → 4 writes, then err_code = 11.
- Assert PRESETN low during WR → sccb_start drops combinationally. After release with auto_start = 0 and a `go` pulse, the sequence restarts from PWR_WAIT with wr_count = 0.
